// File: rtl/bcd_to_bin_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential packed-BCD to binary converter using reverse double-dabble.
// A request is latched on an in_valid/in_ready handshake. The combined
// {bcd,bin} register is then shifted right once per clock, and every BCD
// nibble that reaches 8 or more has 3 subtracted. After 4*NDIG iterations
// the binary result is presented on out_valid/out_ready and is held until
// it is consumed.
//
// Optional feature (compile-time macro BCD_TO_BIN_ERR_CHECK_EN):
//   When the macro is defined, any nibble > 9 at the accept edge flags the
//   request. The conversion still takes the full latency, and the result
//   is reported as out_err=1 with out_bin=0. When the macro is undefined,
//   out_err is always 0 and invalid nibbles simply run through the
//   algorithm.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   clear      synchronous abort back to IDLE (drops any in-flight work)
//   in_valid   request present on in_bcd
//   in_ready   converter can accept a request (registered)
//   in_bcd     NDIG packed BCD digits, ones digit in [3:0]
//   out_valid  out_bin/out_err hold a result
//   out_ready  consumer accepts the result
//   out_bin    binary result (BIN_W bits)
//   out_err    invalid digit seen (only with the error-check macro)
//   busy       high while converting
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
  parameter int NDIG  = 2,
  parameter int BIN_W = 7
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*NDIG-1:0]   in_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    out_bin,
  output logic                out_err,
  output logic                busy
);

  localparam int SW = 4 * NDIG;        // width of both the BCD and binary shift registers
  localparam int CW = $clog2(SW);      // iteration counter width (counts 0..SW-1)

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state_reg;
  logic [SW-1:0]   bcd_reg;
  logic [SW-1:0]   bin_reg;
  logic [CW-1:0]   cnt_reg;
  logic            err_reg;

  // One iteration: right shift of the concatenated register, then correct
  // each BCD nibble (halving a decimal digit pair borrows 10/2=5 into the
  // next lower nibble as 8, so subtracting 3 restores the BCD weight).
  logic [2*SW-1:0] shifted;
  logic [SW-1:0]   bcd_fix;
  logic [SW-1:0]   bin_shift;
  logic            in_bad;

  assign shifted   = {bcd_reg, bin_reg} >> 1;
  assign bin_shift = shifted[SW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_fix
      logic [3:0] nib;
      assign nib = shifted[SW + 4*gi +: 4];
      assign bcd_fix[4*gi +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
    end
  endgenerate

`ifdef BCD_TO_BIN_ERR_CHECK_EN
  logic [NDIG-1:0] nib_bad;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_chk
      assign nib_bad[gi] = (in_bcd[4*gi +: 4] > 4'd9);
    end
  endgenerate
  assign in_bad = |nib_bad;
`else
  assign in_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      // Abort wins over everything, including a same-cycle request.
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // in_ready comes up here on the first edge after reset release.
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            bcd_reg   <= in_bcd;
            bin_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= in_bad;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= CONV;
          end
        end

        CONV: begin
          bcd_reg <= bcd_fix;
          bin_reg <= bin_shift;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(SW - 1)) begin
            // Upper bits of the binary register are zero for valid input.
            out_bin   <= err_reg ? '0 : bin_shift[BIN_W-1:0];
            out_err   <= err_reg;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
